multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 71 +++++++
 rtl/mc_decode.sv | 77 +++++++
 rtl/multicycle_control.sv | 107 ++++++++++
 tb/tb_multicycle_control.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM.
// Macro MULTICYCLE_ADDI_EN adds the ADDIEX/ADDIWB states for opcode 001000.
package mc_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAddr = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExec    = 4'd6,
      StRwb     = 4'd7,
      StBranch  = 4'd8,
`ifdef MULTICYCLE_ADDI_EN
      StJump    = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11
`else
      StJump    = 4'd9
`endif
   } state_e;

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;
   localparam logic [1:0] AluOpAddi  = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'd0;
   localparam logic [1:0] PcSrcAluOut = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;

   localparam logic [1:0] AluBRt      = 2'd0;
   localparam logic [1:0] AluBFour    = 2'd1;
   localparam logic [1:0] AluBSext    = 2'd2;
   localparam logic [1:0] AluBSextSh2 = 2'd3;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   // Last state of every instruction; leaving it retires the instruction.
   function automatic logic is_final(input state_e s);
      case (s)
         StMemWb, StMemWr, StRwb, StBranch, StJump: is_final = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
         StAddiWb: is_final = 1'b1;
`endif
         default: is_final = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational state-to-control decode; only PCWrite looks at Zero (beq).
// Macro MULTICYCLE_ADDI_EN enables the addi state decodes.
module mc_decode
   import mc_pkg::*;
(
   input  state_e i_state,
   input  logic   i_zero,
   output ctrl_t  o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         StFetch: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.ir_write  = 1'b1;
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.alu_src_b = AluBFour;
            o_ctrl.alu_op    = AluOpAdd;
            o_ctrl.pc_source = PcSrcAlu;
         end
         StDecode: begin
            o_ctrl.alu_src_b = AluBSextSh2;
            o_ctrl.alu_op    = AluOpAdd;
         end
         StMemAddr: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = AluBSext;
            o_ctrl.alu_op    = AluOpAdd;
         end
         StMemRd: begin
            o_ctrl.mem_read = 1'b1;
            o_ctrl.iord     = 1'b1;
         end
         StMemWb: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         StMemWr: begin
            o_ctrl.mem_write = 1'b1;
            o_ctrl.iord      = 1'b1;
         end
         StExec: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = AluBRt;
            o_ctrl.alu_op    = AluOpFunct;
         end
         StRwb: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.reg_dst   = 1'b1;
         end
         StBranch: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = AluBRt;
            o_ctrl.alu_op    = AluOpSub;
            o_ctrl.pc_source = PcSrcAluOut;
            o_ctrl.pc_write  = i_zero;
         end
         StJump: begin
            o_ctrl.pc_write  = 1'b1;
            o_ctrl.pc_source = PcSrcJump;
         end
`ifdef MULTICYCLE_ADDI_EN
         StAddiEx: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = AluBSext;
            o_ctrl.alu_op    = AluOpAddi;
         end
         StAddiWb: begin
            o_ctrl.reg_write = 1'b1;
         end
`endif
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with retired-instruction counter.
// Macro MULTICYCLE_ADDI_EN adds the addi (001000) execute/writeback path.
module multicycle_control
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  OpCode,
   input  logic        Zero,
   output logic        PCWrite,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [1:0]  PCSource,
   output logic [3:0]  State,
   output logic        Illegal,
   output logic [31:0] InstrCount
);

   state_e      r_state;
   state_e      w_state_next;
   logic        r_illegal;
   logic        w_illegal_next;
   logic [31:0] r_instr_cnt;
   logic [31:0] w_instr_cnt_next;
   ctrl_t       w_ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StFetch;
         r_illegal   <= 1'b0;
         r_instr_cnt <= 32'd0;
      end else begin
         r_state     <= w_state_next;
         r_illegal   <= w_illegal_next;
         r_instr_cnt <= w_instr_cnt_next;
      end
   end

   always_comb begin
      w_state_next   = StFetch;
      w_illegal_next = 1'b0;
      case (r_state)
         StFetch: w_state_next = StDecode;
         StDecode: begin
            case (OpCode)
               OpRType:   w_state_next = StExec;
               OpLw, OpSw: w_state_next = StMemAddr;
               OpBeq:     w_state_next = StBranch;
               OpJ:       w_state_next = StJump;
`ifdef MULTICYCLE_ADDI_EN
               OpAddi:    w_state_next = StAddiEx;
`endif
               default: begin
                  w_state_next   = StFetch;
                  w_illegal_next = 1'b1;
               end
            endcase
         end
         StMemAddr: w_state_next = (OpCode == OpSw) ? StMemWr : StMemRd;
         StMemRd:   w_state_next = StMemWb;
         StExec:    w_state_next = StRwb;
`ifdef MULTICYCLE_ADDI_EN
         StAddiEx:  w_state_next = StAddiWb;
`endif
         default:   w_state_next = StFetch;
      endcase
   end

   // Every final state exits to FETCH, so retiring is just "leaving a final state".
   always_comb begin
      w_instr_cnt_next = r_instr_cnt;
      if (is_final(r_state)) begin
         w_instr_cnt_next = r_instr_cnt + 32'd1;
      end
   end

   mc_decode u_decode (
      .i_state (r_state),
      .i_zero  (Zero),
      .o_ctrl  (w_ctrl)
   );

   assign PCWrite    = w_ctrl.pc_write;
   assign IorD       = w_ctrl.iord;
   assign MemRead    = w_ctrl.mem_read;
   assign MemWrite   = w_ctrl.mem_write;
   assign IRWrite    = w_ctrl.ir_write;
   assign RegDst     = w_ctrl.reg_dst;
   assign RegWrite   = w_ctrl.reg_write;
   assign MemtoReg   = w_ctrl.mem_to_reg;
   assign ALUSrcA    = w_ctrl.alu_src_a;
   assign ALUSrcB    = w_ctrl.alu_src_b;
   assign ALUOp      = w_ctrl.alu_op;
   assign PCSource   = w_ctrl.pc_source;
   assign State      = r_state;
   assign Illegal    = r_illegal;
   assign InstrCount = r_instr_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs queued at issue time.
// Honours MULTICYCLE_ADDI_EN for the addi path expectation.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  OpCode = 6'd0;
   logic        Zero = 1'b0;
   logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic [3:0]  State;
   logic        Illegal;
   logic [31:0] InstrCount;

   multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .OpCode     (OpCode),
      .Zero       (Zero),
      .PCWrite    (PCWrite),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegDst     (RegDst),
      .RegWrite   (RegWrite),
      .MemtoReg   (MemtoReg),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUOp      (ALUOp),
      .PCSource   (PCSource),
      .State      (State),
      .Illegal    (Illegal),
      .InstrCount (InstrCount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic        pcw, iord, mr, mw, irw, rdst, rw, m2r, asa;
      logic [1:0]  asb, aop, pcs;
      logic        ill;
      logic [31:0] cnt;
   } obs_t;

   obs_t        act;
   obs_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   logic [31:0] m_cnt = 32'd0;
   bit          m_ill_pending = 1'b0;

   assign act = {State, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, MemtoReg,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, InstrCount};

   // Output table straight from the state descriptions; anything unlisted is 0.
   function automatic obs_t state_outputs(input int st, input logic z);
      obs_t o = '0;
      o.st = st[3:0];
      case (st)
         0:  begin o.mr = 1; o.irw = 1; o.pcw = 1; o.asb = 2'd1; end
         1:  begin o.asb = 2'd3; end
         2:  begin o.asa = 1; o.asb = 2'd2; end
         3:  begin o.mr = 1; o.iord = 1; end
         4:  begin o.rw = 1; o.m2r = 1; end
         5:  begin o.mw = 1; o.iord = 1; end
         6:  begin o.asa = 1; o.aop = 2'b10; end
         7:  begin o.rw = 1; o.rdst = 1; end
         8:  begin o.asa = 1; o.aop = 2'b01; o.pcs = 2'd1; o.pcw = z; end
         9:  begin o.pcw = 1; o.pcs = 2'd2; end
         10: begin o.asa = 1; o.asb = 2'd2; o.aop = 2'b11; end
         11: begin o.rw = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   // Called at posedge+1 with the DUT in FETCH; queues one record per cycle of the instruction.
   task automatic issue(input logic [5:0] op, input logic z, input bit do_force);
      int path[$];
      bit legal = 1'b1;
      obs_t r;
      case (op)
         6'b000000: path = '{0, 1, 6, 7};
         6'b100011: path = '{0, 1, 2, 3, 4};
         6'b101011: path = '{0, 1, 2, 5};
         6'b000100: path = '{0, 1, 8};
         6'b000010: path = '{0, 1, 9};
`ifdef MULTICYCLE_ADDI_EN
         6'b001000: path = '{0, 1, 10, 11};
`endif
         default: begin path = '{0, 1}; legal = 1'b0; end
      endcase
      if (do_force) begin
         force dut.r_instr_cnt = 32'hFFFF_FFFF;
         m_cnt = 32'hFFFF_FFFF;
      end
      for (int i = 0; i < path.size(); i++) begin
         r = state_outputs(path[i], z);
         r.ill = (i == 0) ? m_ill_pending : 1'b0;
         r.cnt = m_cnt;
         exp_q.push_back(r);
      end
      m_ill_pending = !legal;
      if (legal) m_cnt = m_cnt + 32'd1;
      OpCode = op;
      Zero = z;
      for (int i = 0; i < path.size(); i++) begin
         @(posedge clk);
         #1;
         if (do_force && i == 0) release dut.r_instr_cnt;
      end
   endtask

   always @(negedge clk) begin
      obs_t e;
      if (mon_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL cycle: no expected entry, got state=%0d cnt=%0h", act.st, act.cnt);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               bad++;
               $display("FAIL cycle t=%0t: got st=%0d ctl=%h cnt=%0h expected st=%0d ctl=%h cnt=%0h",
                        $time, act.st, act[47:32], act.cnt, e.st, e[47:32], e.cnt);
            end
         end
      end
   end

   initial begin
      logic [5:0] op;
      logic [5:0] legal_ops [6];
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {28'd0, State}, 32'd0);
      chk("reset_count", InstrCount, 32'd0);
      chk("reset_illegal", {31'd0, Illegal}, 32'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;

      issue(6'b000000, 1'b0, 1'b0);
      issue(6'b100011, 1'b0, 1'b0);
      issue(6'b101011, 1'b1, 1'b0);
      issue(6'b000100, 1'b1, 1'b0);
      issue(6'b000100, 1'b0, 1'b0);
      issue(6'b000010, 1'b0, 1'b0);
      issue(6'b111111, 1'b0, 1'b0);
      issue(6'b111111, 1'b1, 1'b0);
      issue(6'b001000, 1'b0, 1'b0);
      issue(6'b000000, 1'b1, 1'b0);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
         else op = 6'($urandom);
         issue(op, 1'($urandom), 1'b0);
      end

      // Abandon an lw in MEMRD with an asynchronous reset between clock edges.
      mon_en = 1'b0;
      OpCode = 6'b100011;
      repeat (3) @(posedge clk);
      #1;
      chk("midop_in_memrd", {28'd0, State}, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midop_state", {28'd0, State}, 32'd0);
      chk("midop_count", InstrCount, 32'd0);
      chk("midop_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("midop_illegal", {31'd0, Illegal}, 32'd0);
      @(posedge clk);
      #1;
      m_cnt = 32'd0;
      m_ill_pending = 1'b0;
      rst_n = 1'b1;
      mon_en = 1'b1;

      issue(6'b000010, 1'b0, 1'b1);
      issue(6'b000000, 1'b0, 1'b0);
      issue(6'b001000, 1'b1, 1'b0);
      issue(6'b000100, 1'b1, 1'b0);

      mon_en = 1'b0;
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("final_count", InstrCount, m_cnt);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
